mult_part: RTL and testbench



---
 rtl/kuz_gf_pkg.sv | 17 +
 rtl/gf_xtime.sv | 16 +
 rtl/mult_part.sv | 87 ++++++++
 tb/tb_mult_part.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/kuz_gf_pkg.sv
// Shared Kuznechik GF(2^8) definitions.
// Field polynomial x^8+x^7+x^6+x+1 (0x1C3). Only the low byte is stored,
// because bit 8 is always implied by the shift.
//   KUZ_POLY  : low byte of the reduction polynomial
//   gf_byte_t : one field element
//   gf_xtime  : multiply by x (doubling) modulo the polynomial
package kuz_gf_pkg;

  typedef logic [7:0] gf_byte_t;

  localparam gf_byte_t KUZ_POLY = 8'hC3;

  function automatic gf_byte_t gf_xtime(input gf_byte_t a, input gf_byte_t poly);
    return {a[6:0], 1'b0} ^ (a[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Combinational GF(2^8) doubling: dout = din * x mod (0x100 | POLY).
// Ports:
//   din  in  8  field element
//   dout out 8  doubled element
module gf_xtime
  import kuz_gf_pkg::*;
#(
  parameter gf_byte_t POLY = KUZ_POLY
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = kuz_gf_pkg::gf_xtime(din, POLY);

endmodule

// File: rtl/mult_part.sv
// One step of the Kuznechik shift-and-add GF(2^8) multiplier.
// Accumulates a into c when b is set, then doubles a modulo the field
// polynomial. Eight of these in a chain make a full byte multiply.
// Build option: MULT_PART_REG_EN
//   defined   : a_q / c_q / out_valid are a one-cycle registered stage
//   undefined : a_q / c_q / out_valid are wires equal to a_res / c_res / in_valid
// Ports:
//   clk, rst_n   clock and async active-low reset (registered stage only)
//   a            current multiplicand
//   b            current multiplier bit
//   c            partial-product accumulator in
//   in_valid     qualifies a, b, c for the stage
//   a_res, c_res combinational doubled multiplicand / accumulator out
//   a_q, c_q     staged a_res / c_res
//   out_valid    qualifies a_q / c_q
module mult_part
  import kuz_gf_pkg::*;
#(
  parameter gf_byte_t POLY = KUZ_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic       b,
  input  logic [7:0] c,
  input  logic       in_valid,
  output logic [7:0] a_res,
  output logic [7:0] c_res,
  output logic [7:0] a_q,
  output logic [7:0] c_q,
  output logic       out_valid
);

  gf_xtime #(.POLY(POLY)) u_xtime (
    .din  (a),
    .dout (a_res)
  );

  // Add uses the unshifted a: accumulate first, then double.
  assign c_res = b ? (c ^ a) : c;

`ifdef MULT_PART_REG_EN

  gf_byte_t stage_a_d, stage_a_q;
  gf_byte_t stage_c_d, stage_c_q;
  logic     stage_v_d, stage_v_q;

  always_comb begin
    stage_a_d = stage_a_q;
    stage_c_d = stage_c_q;
    stage_v_d = 1'b0;
    if (in_valid) begin
      stage_a_d = a_res;
      stage_c_d = c_res;
      stage_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_a_q <= 8'h00;
      stage_c_q <= 8'h00;
      stage_v_q <= 1'b0;
    end else begin
      stage_a_q <= stage_a_d;
      stage_c_q <= stage_c_d;
      stage_v_q <= stage_v_d;
    end
  end

  assign a_q       = stage_a_q;
  assign c_q       = stage_c_q;
  assign out_valid = stage_v_q;

`else

  assign a_q       = a_res;
  assign c_q       = c_res;
  assign out_valid = in_valid;

  // Clock and reset have no load in the unstaged build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

`endif

endmodule

// File: tb/tb_mult_part.sv
module tb_mult_part;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic       b;
  logic [7:0] c;
  logic       in_valid;
  logic [7:0] a_res;
  logic [7:0] c_res;
  logic [7:0] a_q;
  logic [7:0] c_q;
  logic       out_valid;

  int n_cmp;
  int n_bad;

  // Expected staged outputs
  logic [7:0] exp_aq;
  logic [7:0] exp_cq;
  logic       exp_ov;

  mult_part dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .in_valid  (in_valid),
    .a_res     (a_res),
    .c_res     (c_res),
    .a_q       (a_q),
    .c_q       (c_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Reference: multiply by x as integer arithmetic, reduce by the full
  // 9-bit polynomial when the product overflows a byte.
  function automatic logic [7:0] ref_double(input logic [7:0] x);
    int v;
    v = int'(x) * 2;
    if (v > 255) v = v ^ 'h1C3;
    return v[7:0];
  endfunction

  // Reference: GF(2) addition of a into c when the multiplier bit is set.
  function automatic logic [7:0] ref_accum(input logic [7:0] ai, input logic bi,
                                           input logic [7:0] ci);
    return (bi == 1'b1) ? (ci ^ ai) : ci;
  endfunction

  // Drive one step at the falling edge, check the combinational results,
  // then check the staged outputs after the next rising edge.
  task automatic apply(input logic [7:0] ai, input logic bi, input logic [7:0] ci,
                       input logic vi, input logic [7:0] ea, input logic [7:0] ec);
    @(negedge clk);
    a = ai; b = bi; c = ci; in_valid = vi;
    #1;
    chk("a_res", a_res, ea);
    chk("c_res", c_res, ec);
`ifdef MULT_PART_REG_EN
    if (vi) begin
      exp_aq = ea;
      exp_cq = ec;
    end
    exp_ov = vi;
    @(posedge clk);
    #1;
    chk("a_q", a_q, exp_aq);
    chk("c_q", c_q, exp_cq);
    chk("out_valid", {7'b0, out_valid}, {7'b0, exp_ov});
`else
    chk("a_q_wire", a_q, ea);
    chk("c_q_wire", c_q, ec);
    chk("out_valid_wire", {7'b0, out_valid}, {7'b0, vi});
`endif
  endtask

  typedef struct {
    logic [7:0] a;
    logic       b;
    logic [7:0] c;
    logic [7:0] ea;
    logic [7:0] ec;
  } vec_t;

  vec_t dir_v [7];

  initial begin
    logic [7:0] ra, rc;
    logic       rb, rv;

    n_cmp = 0;
    n_bad = 0;
    exp_aq = 8'h00;
    exp_cq = 8'h00;
    exp_ov = 1'b0;
    rst_n = 1'b0;
    a = 8'h00; b = 1'b0; c = 8'h00; in_valid = 1'b0;

    dir_v[0] = '{8'h80, 1'b1, 8'h81, 8'hC3, 8'h01};
    dir_v[1] = '{8'hC0, 1'b1, 8'hC3, 8'h43, 8'h03};
    dir_v[2] = '{8'hFF, 1'b1, 8'h00, 8'h3D, 8'hFF};
    dir_v[3] = '{8'h57, 1'b1, 8'h83, 8'hAE, 8'hD4};
    dir_v[4] = '{8'hBE, 1'b1, 8'hEF, 8'hBF, 8'h51};
    dir_v[5] = '{8'h00, 1'b1, 8'h00, 8'h00, 8'h00};
    dir_v[6] = '{8'h57, 1'b0, 8'h83, 8'hAE, 8'h83};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_a_q", a_q, 8'h00);
    chk("rst_c_q", c_q, 8'h00);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    rst_n = 1'b1;

    // First capture, then a bubble that must hold the staged data
    apply(8'h03, 1'b1, 8'h07, 1'b1, 8'h06, 8'h04);
    apply(8'h55, 1'b1, 8'h0F, 1'b0, 8'hAA, 8'h5A);

    // Directed vectors with hand-computed results
    foreach (dir_v[i])
      apply(dir_v[i].a, dir_v[i].b, dir_v[i].c, 1'b1, dir_v[i].ea, dir_v[i].ec);

    // Randomized against the reference model
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rc = 8'($urandom_range(0, 255));
      rb = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      apply(ra, rb, rc, rv, ref_double(ra), ref_accum(ra, rb, rc));
    end

`ifdef MULT_PART_REG_EN
    // Async reset between edges with nonzero staged data
    apply(8'hBE, 1'b1, 8'hEF, 1'b1, 8'hBF, 8'h51);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_a_q", a_q, 8'h00);
    chk("async_c_q", c_q, 8'h00);
    chk("async_out_valid", {7'b0, out_valid}, 8'h00);
    exp_aq = 8'h00;
    exp_cq = 8'h00;
    exp_ov = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h80, 1'b1, 8'h81, 1'b1, 8'hC3, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
